// File: rtl/wb_trace_checker.sv
// -----------------------------------------------------------------------------
// wb_trace_checker
//
// Write-back trace checker for the OpenMIPS regfile write port. A script of
// expected (register, value) writes is loaded while idle. After a start pulse,
// every snooped regfile write to a non-zero register is compared in order
// against the script. The result is PASS, the first mismatch (address or
// data), or a timeout. Cycle and match counts are reported with the result.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   exp_we     script load strobe (honoured in IDLE only)
//   exp_idx    script entry to write
//   exp_addr   expected destination register
//   exp_data   expected write value
//   exp_len    number of entries to check, sampled on start, clamped to DEPTH
//   start      one-cycle pulse that begins a run
//   clear      one-cycle pulse that returns to IDLE from any state
//   wb_we      snooped regfile write enable
//   wb_waddr   snooped write address
//   wb_wdata   snooped write data
//   busy       high while a run is in progress
//   done       high once the run has a result (PASS or FAIL)
//   pass       high when the run completed with every write matched
//   fail_code  0 none, 1 address mismatch, 2 data mismatch, 3 timeout
//   fail_idx   script index at the failure
//   match_cnt  writes matched so far
//   cycle_cnt  cycles spent running
// -----------------------------------------------------------------------------
module wb_trace_checker #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 16,
    parameter int PTR_W   = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exp_we,
    input  logic [PTR_W-1:0]  exp_idx,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [PTR_W:0]    exp_len,
    input  logic              start,
    input  logic              clear,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [PTR_W-1:0]  fail_idx,
    output logic [PTR_W:0]    match_cnt,
    output logic [CNT_W-1:0]  cycle_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    localparam logic [1:0]       FC_NONE    = 2'd0;
    localparam logic [1:0]       FC_ADDR    = 2'd1;
    localparam logic [1:0]       FC_DATA    = 2'd2;
    localparam logic [1:0]       FC_TIMEOUT = 2'd3;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] script_addr [DEPTH];
    logic [DATA_W-1:0] script_data [DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W:0]    len;

    logic [PTR_W:0]    len_in;
    logic [PTR_W:0]    match_inc;
    logic              snoop;
    logic              at_timeout;
    logic              load;
    logic              launch;
    logic              in_run;
    logic              do_match;
    logic              set_fail;
    logic [1:0]        code_next;

    assign len_in     = (int'(exp_len) > DEPTH) ? (PTR_W+1)'(DEPTH) : exp_len;
    assign match_inc  = match_cnt + (PTR_W+1)'(1);
    // Writes to $0 never reach the regfile, so they are not part of the trace.
    assign snoop      = wb_we && (wb_waddr != '0);
    assign at_timeout = (cycle_cnt == CNT_LAST);
    // A start in the same cycle wins and the load is dropped.
    assign load       = (state == S_IDLE) && exp_we && !start && (int'(exp_idx) < DEPTH);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_next = state;
        launch     = 1'b0;
        in_run     = 1'b0;
        do_match   = 1'b0;
        set_fail   = 1'b0;
        code_next  = FC_NONE;

        if (clear) begin
            state_next = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        launch     = 1'b1;
                        state_next = (len_in == '0) ? S_PASS : S_RUN;
                    end
                end
                S_RUN: begin
                    in_run = 1'b1;
                    if (snoop) begin
                        if (wb_waddr != script_addr[ptr]) begin
                            set_fail  = 1'b1;
                            code_next = FC_ADDR;
                        end else if (wb_wdata != script_data[ptr]) begin
                            set_fail  = 1'b1;
                            code_next = FC_DATA;
                        end else begin
                            do_match = 1'b1;
                            if (match_inc == len) state_next = S_PASS;
                        end
                    end
                    // Timeout only fires when this edge neither completed
                    // nor mismatched; both of those take precedence.
                    if (at_timeout && !set_fail && state_next == S_RUN) begin
                        set_fail  = 1'b1;
                        code_next = FC_TIMEOUT;
                    end
                    if (set_fail) state_next = S_FAIL;
                end
                default: ; // PASS and FAIL hold until clear
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= FC_NONE;
            fail_idx  <= '0;
            match_cnt <= '0;
            cycle_cnt <= '0;
            ptr       <= '0;
            len       <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next == S_RUN);
            done  <= (state_next == S_PASS) || (state_next == S_FAIL);
            pass  <= (state_next == S_PASS);

            if (launch) begin
                ptr       <= '0;
                match_cnt <= '0;
                cycle_cnt <= '0;
                fail_code <= FC_NONE;
                fail_idx  <= '0;
                len       <= len_in;
            end
            // The counter parks at TIMEOUT-1: that is the edge that ends the
            // run, so it can never wrap.
            if (in_run && !at_timeout) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (do_match) begin
                ptr       <= ptr + PTR_W'(1);
                match_cnt <= match_inc;
            end
            if (set_fail) begin
                fail_code <= code_next;
                fail_idx  <= ptr;
            end
        end
    end

    // NOTE: the script store is plain RAM with no reset; its contents are
    // undefined after reset and the script must be reloaded.
    always_ff @(posedge clk) begin
        if (load) begin
            script_addr[exp_idx] <= exp_addr;
            script_data[exp_idx] <= exp_data;
        end
    end

endmodule

// File: doc/wb_trace_checker.md
# wb_trace_checker

Parametrised write-back trace checker that sits beside the OpenMIPS regfile write port in the min-SOPC simulation harness. It replaces hand inspection of dumped `regs[n]` waveforms with a self-checking pass/fail result. It holds a loadable script of expected (register, value) writes, snoops every regfile write during a run, and compares each one in order. It reports PASS, the first mismatch, or a timeout, together with cycle and match counts.

## Interface
Parameters:
- DATA_W, 32, regfile data width
- ADDR_W, 5, regfile address width
- DEPTH, 16, number of script entries
- PTR_W, 4, script index width; DEPTH ≤ 2^PTR_W
- CNT_W, 16, cycle counter width
- TIMEOUT, 1024, maximum run length in cycles; must be < 2^CNT_W

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- exp_we  in  1  script load strobe
- exp_idx  in  PTR_W  script entry to write
- exp_addr  in  ADDR_W  expected destination register
- exp_data  in  DATA_W  expected write value
- exp_len  in  PTR_W+1  number of script entries to check; sampled on start
- start  in  1  one-cycle pulse that begins a run
- clear  in  1  one-cycle pulse; aborts or acknowledges, returns to IDLE
- wb_we  in  1  snooped regfile write enable
- wb_waddr  in  ADDR_W  snooped write address
- wb_wdata  in  DATA_W  snooped write data
- busy  out  1  high in RUN
- done  out  1  high in PASS or FAIL
- pass  out  1  high in PASS
- fail_code  out  2  0 none, 1 address mismatch, 2 data mismatch, 3 timeout
- fail_idx  out  PTR_W  script index at failure
- match_cnt  out  PTR_W+1  writes matched so far
- cycle_cnt  out  CNT_W  cycles spent in RUN

## Operation
- FSM states: IDLE, RUN, PASS, FAIL.
- Reset: state IDLE.
  - All outputs are 0; the internal script pointer is 0.
  - The script memory is not reset and must be reloaded after reset.
- Script load: exp_we writes entry exp_idx in IDLE only. It is ignored in other states.
- IDLE, start=1:
  - Latch len = min(exp_len, DEPTH).
  - Clear the pointer, match_cnt, cycle_cnt and fail fields.
  - len=0: go to PASS. Otherwise go to RUN.
- RUN, every cycle: cycle_cnt += 1.
- RUN, wb_we=1 and wb_waddr≠0 (writes to $0 are ignored):
  - Address differs from entry[ptr]: go to FAIL, fail_code=1, fail_idx=ptr.
  - Address matches but data differs: go to FAIL, fail_code=2, fail_idx=ptr.
  - Both match: ptr += 1 and match_cnt += 1. If this was entry len-1, go to PASS.
- RUN, cycle_cnt = TIMEOUT-1 with no completion this cycle: go to FAIL, fail_code=3, fail_idx=ptr.
- PASS and FAIL are sticky. The following are ignored in these states: snooped writes, start, exp_we. Counters freeze.
- clear in any state: go to IDLE.
  - Fail fields and counters keep their values until the next start.
  - pass, done and busy drop.
- clear has priority over start in the same cycle.
- In IDLE, start has priority over exp_we in the same cycle; the load is dropped.

## Timing
- All outputs are registered.
- A write sampled at edge N is reflected in match_cnt, pass or fail at edge N (visible in cycle N+1).
- start at edge N: busy=1 in cycle N+1. The first snooped write is compared at edge N+1.
- Completion and timeout on the same edge: the match wins and the result is PASS.
- A mismatch and timeout on the same edge: the mismatch code (1 or 2) wins.
- cycle_cnt never wraps: TIMEOUT < 2^CNT_W.
- Throughput: one compare per cycle. Back-to-back writes on consecutive cycles are all checked.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0, with no clock required.

## Test plan
- Load 3 entries ($1=0x1100, $2=0x0020, $3=0x1120), exp_len=3, start, drive matching writes on consecutive cycles -> pass=1 one cycle after the third write; match_cnt=3; cycle_cnt=3.
- Same script; third write drives $3=0x1121 -> fail_code=2, fail_idx=2, match_cnt=2, done=1, pass=0; later writes change nothing.
- Same script; a write to $0=0xDEAD inserted between matches, and the second write goes to $4 -> the $0 write is ignored; fail_code=1, fail_idx=1.
- TIMEOUT=8, exp_len=2, only one matching write driven -> fail_code=3 at cycle_cnt=7, match_cnt=1.
- exp_len=0 start -> pass=1 the next cycle. exp_len=DEPTH+5 -> clamps to DEPTH; PASS after DEPTH matches.
- Reset low mid-RUN between clock edges -> busy, done and counters drop to 0 immediately. clear in PASS -> IDLE; a new start with a reloaded script runs cleanly.
